// File: rtl/ssd1331_pkg.sv
// SSD1331 opcode map and argument-count table.
// Shared by the SPI receiver and the OLED master bench.
package ssd1331_pkg;

  localparam logic [7:0] SET_COL   = 8'h15;
  localparam logic [7:0] SET_ROW   = 8'h75;
  localparam logic [7:0] DISP_ON   = 8'hAF;
  localparam logic [7:0] DISP_OFF  = 8'hAE;
  localparam logic [7:0] CLEAR     = 8'h25;
  localparam logic [7:0] DRAW_RECT = 8'h22;
  localparam logic [7:0] DRAW_LINE = 8'h21;
  localparam logic [7:0] COPY      = 8'h23;
  localparam logic [7:0] NOP       = 8'hBC;

  typedef enum logic {
    S_CMD,
    S_ARG
  } parse_state_t;

  function automatic logic [5:0] arg_count(input logic [7:0] op);
    case (op)
      8'h81, 8'h82, 8'h83, 8'h87,
      8'h8A, 8'h8B, 8'h8C, 8'hA0,
      8'hA1, 8'hA2, 8'hA8, 8'hAD,
      8'hB0, 8'hB1, 8'hB3, 8'hBB,
      8'hBE, 8'hFD, 8'h26:        arg_count = 6'd1;
      8'h15, 8'h75:               arg_count = 6'd2;
      8'h24, 8'h25:               arg_count = 6'd4;
      8'h27:                      arg_count = 6'd5;
      8'h23:                      arg_count = 6'd6;
      8'h21:                      arg_count = 6'd7;
      8'h22:                      arg_count = 6'd10;
      8'hB8:                      arg_count = 6'd32;
      default:                    arg_count = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1331_spi_rx_byte.sv
// SPI mode-0 byte receiver: pin synchronisers, sck rise detect,
// MSB-first shifter; cs high drops any partial byte.
module spi_slave_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [SYNC_STAGES-1:0] cs_q, cs_d;
  logic [SYNC_STAGES-1:0] dc_q, dc_d;
  logic [SYNC_STAGES-1:0] sck_q, sck_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic       sck_prev_q, sck_prev_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       bdc_q, bdc_d;
  logic       cs_s, dc_s, sck_s, mosi_s, sck_rise;

  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign dc_s     = dc_q[SYNC_STAGES-1];
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  always_comb begin
    cs_d       = {cs_q[SYNC_STAGES-2:0], spi_cs};
    dc_d       = {dc_q[SYNC_STAGES-2:0], spi_dc};
    sck_d      = {sck_q[SYNC_STAGES-2:0], spi_sck};
    mosi_d     = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d = sck_s;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    bdc_d      = bdc_q;
    if (cs_s) begin
      cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d = {shift_q[5:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        valid_d = 1'b1;
        data_d  = {shift_q, mosi_s};
        bdc_d   = dc_s;
      end
    end
  end

  // cs syncs reset to the idle-high level
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cs_q       <= '1;
      dc_q       <= '0;
      sck_q      <= '0;
      mosi_q     <= '0;
      sck_prev_q <= 1'b0;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      bdc_q      <= 1'b0;
    end else begin
      cs_q       <= cs_d;
      dc_q       <= dc_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      sck_prev_q <= sck_prev_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      bdc_q      <= bdc_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_dc    = bdc_q;

endmodule

// File: rtl/ssd1331_spi_rx.sv
// SSD1331 bus monitor: command/argument parser, address window
// and RGB565 pixel assembler on top of the SPI byte receiver.
module ssd1331_spi_rx
  import ssd1331_pkg::*;
#(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_cs,
  input  logic        spi_dc,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        cmd_done,
  output logic [7:0]  cmd_op,
  output logic        pix_we,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        display_on
);

  localparam logic [6:0] X_MAX = 7'(WIDTH - 1);
  localparam logic [5:0] Y_MAX = 6'(HEIGHT - 1);

  logic       rx_valid, rx_dc;
  logic [7:0] rx_data;

  spi_slave_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .spi_cs    (spi_cs),
    .spi_dc    (spi_dc),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .byte_dc   (rx_dc)
  );

  parse_state_t state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [5:0]  left_q, left_d;
  logic [6:0]  arg0_q, arg0_d;
  logic        done_q, done_d;
  logic [7:0]  cop_q, cop_d;
  logic        disp_q, disp_d;
  logic [6:0]  cs_q, cs_d, ce_q, ce_d;
  logic [5:0]  rs_q, rs_d, re_q, re_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic        ph_q, ph_d;
  logic [7:0]  hi_q, hi_d;
  logic        we_q, we_d;
  logic [6:0]  px_q, px_d;
  logic [5:0]  py_q, py_d;
  logic [15:0] rgb_q, rgb_d;
  logic        fin;
  logic [7:0]  fin_op;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    left_d  = left_q;
    arg0_d  = arg0_q;
    done_d  = 1'b0;
    cop_d   = cop_q;
    disp_d  = disp_q;
    cs_d    = cs_q;
    ce_d    = ce_q;
    rs_d    = rs_q;
    re_d    = re_q;
    x_d     = x_q;
    y_d     = y_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    px_d    = px_q;
    py_d    = py_q;
    rgb_d   = rgb_q;
    fin     = 1'b0;
    fin_op  = op_q;
    if (rx_valid && !rx_dc) begin
      ph_d = 1'b0;
      if (state_q == S_CMD) begin
        op_d   = rx_data;
        fin_op = rx_data;
        left_d = arg_count(rx_data);
        if (arg_count(rx_data) == 6'd0) fin = 1'b1;
        else state_d = S_ARG;
      end else begin
        if (left_q == arg_count(op_q)) arg0_d = rx_data[6:0];
        left_d = left_q - 6'd1;
        if (left_q == 6'd1) begin
          fin     = 1'b1;
          state_d = S_CMD;
        end
      end
    end else if (rx_valid && !ph_q) begin
      hi_d = rx_data;
      ph_d = 1'b1;
    end else if (rx_valid) begin
      ph_d  = 1'b0;
      we_d  = 1'b1;
      px_d  = x_q;
      py_d  = y_q;
      rgb_d = {hi_q, rx_data};
      // the panel edge also wraps, so start>end cannot lock up
      if (x_q == ce_q || x_q == X_MAX) begin
        x_d = cs_q;
        if (y_q == re_q || y_q == Y_MAX) y_d = rs_q;
        else y_d = y_q + 6'd1;
      end else begin
        x_d = x_q + 7'd1;
      end
    end
    if (fin) begin
      done_d = 1'b1;
      cop_d  = fin_op;
      unique case (1'b1)
        fin_op == SET_COL: begin
          cs_d = arg0_q;
          ce_d = rx_data[6:0];
          x_d  = arg0_q;
        end
        fin_op == SET_ROW: begin
          rs_d = arg0_q[5:0];
          re_d = rx_data[5:0];
          y_d  = arg0_q[5:0];
        end
        fin_op == DISP_ON:  disp_d = 1'b1;
        fin_op == DISP_OFF: disp_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_CMD;
      op_q    <= 8'd0;
      left_q  <= 6'd0;
      arg0_q  <= 7'd0;
      done_q  <= 1'b0;
      cop_q   <= 8'd0;
      disp_q  <= 1'b0;
      cs_q    <= 7'd0;
      ce_q    <= X_MAX;
      rs_q    <= 6'd0;
      re_q    <= Y_MAX;
      x_q     <= 7'd0;
      y_q     <= 6'd0;
      ph_q    <= 1'b0;
      hi_q    <= 8'd0;
      we_q    <= 1'b0;
      px_q    <= 7'd0;
      py_q    <= 6'd0;
      rgb_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      left_q  <= left_d;
      arg0_q  <= arg0_d;
      done_q  <= done_d;
      cop_q   <= cop_d;
      disp_q  <= disp_d;
      cs_q    <= cs_d;
      ce_q    <= ce_d;
      rs_q    <= rs_d;
      re_q    <= re_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      px_q    <= px_d;
      py_q    <= py_d;
      rgb_q   <= rgb_d;
    end
  end

  assign byte_valid = rx_valid;
  assign byte_data  = rx_data;
  assign byte_dc    = rx_dc;
  assign cmd_done   = done_q;
  assign cmd_op     = cop_q;
  assign pix_we     = we_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign pix_rgb    = rgb_q;
  assign display_on = disp_q;

endmodule

// File: tb/tb_ssd1331_spi_rx.sv
// Bench for ssd1331_spi_rx: SPI stimulus from command/pixel tables,
// scoreboard queues for bytes, commands and pixel writes.
module tb_ssd1331_spi_rx;

  localparam int HALF = 5;

  typedef struct {
    logic [7:0]      op;
    int              n;
    logic [9:0][7:0] a;
  } cmd_t;

  typedef struct {
    logic [15:0] rgb;
    logic [6:0]  x;
    logic [5:0]  y;
  } pix_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_dc = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        byte_valid, byte_dc, cmd_done, pix_we, display_on;
  logic [7:0]  byte_data, cmd_op;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic [15:0] pix_rgb;

  int n_chk = 0;
  int n_fail = 0;
  int n_bytes = 0;
  int n_cmds = 0;
  int n_pix = 0;

  logic [8:0]  exp_bytes[$];
  logic [7:0]  exp_ops[$];
  logic [28:0] exp_pix[$];

  cmd_t init_tbl[28];
  pix_t pix_tbl[7];

  ssd1331_spi_rx dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi_cs    (spi_cs),
    .spi_dc    (spi_dc),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .cmd_done  (cmd_done),
    .cmd_op    (cmd_op),
    .pix_we    (pix_we),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_rgb   (pix_rgb),
    .display_on(display_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event %0h, expected none", name, act);
  endtask

  always @(negedge clk) begin
    if (byte_valid) begin
      n_bytes++;
      if (exp_bytes.size() == 0) unexpected("byte", {byte_dc, byte_data});
      else check("byte", {byte_dc, byte_data}, exp_bytes.pop_front());
    end
    if (cmd_done) begin
      n_cmds++;
      if (exp_ops.size() == 0) unexpected("cmd_op", cmd_op);
      else check("cmd_op", cmd_op, exp_ops.pop_front());
    end
    if (pix_we) begin
      n_pix++;
      if (exp_pix.size() == 0) unexpected("pixel", {pix_x, pix_y, pix_rgb});
      else check("pixel", {pix_x, pix_y, pix_rgb}, exp_pix.pop_front());
    end
  end

  function automatic cmd_t mk(input logic [7:0] op, input int n,
                              input logic [79:0] a);
    cmd_t c;
    c.op = op;
    c.n  = n;
    c.a  = a;
    return c;
  endfunction

  function automatic pix_t mp(input logic [15:0] rgb,
                              input logic [6:0] x, input logic [5:0] y);
    pix_t p;
    p.rgb = rgb;
    p.x   = x;
    p.y   = y;
    return p;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      wait_clk(HALF);
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    spi_dc = dc;
    exp_bytes.push_back({dc, b});
    send_bits(b, 8);
  endtask

  task automatic send_cmd(input cmd_t c);
    exp_ops.push_back(c.op);
    send_byte(1'b0, c.op);
    for (int i = 0; i < c.n; i++) send_byte(1'b0, c.a[i]);
  endtask

  task automatic send_pix(input pix_t p);
    exp_pix.push_back({p.x, p.y, p.rgb});
    send_byte(1'b1, p.rgb[15:8]);
    send_byte(1'b1, p.rgb[7:0]);
  endtask

  task automatic drain(input string name);
    wait_clk(20);
    check({name, "_bytes_left"}, exp_bytes.size(), 0);
    check({name, "_ops_left"}, exp_ops.size(), 0);
    check({name, "_pix_left"}, exp_pix.size(), 0);
  endtask

  task automatic check_zero(input string name);
    check(name, {byte_valid, byte_data, byte_dc, cmd_done, cmd_op},
          32'd0);
    check({name, "_pix"}, {pix_we, pix_x, pix_y, pix_rgb, display_on},
          32'd0);
  endtask

  initial begin
    int b0, c0, p0;

    init_tbl[0]  = mk(8'hFD, 1, 80'h12);
    init_tbl[1]  = mk(8'hAE, 0, 80'h0);
    init_tbl[2]  = mk(8'hA0, 1, 80'h72);
    init_tbl[3]  = mk(8'hA1, 1, 80'h00);
    init_tbl[4]  = mk(8'hA2, 1, 80'h00);
    init_tbl[5]  = mk(8'hA4, 0, 80'h0);
    init_tbl[6]  = mk(8'hA8, 1, 80'h3F);
    init_tbl[7]  = mk(8'hAD, 1, 80'h8E);
    init_tbl[8]  = mk(8'hB0, 1, 80'h0B);
    init_tbl[9]  = mk(8'hB1, 1, 80'h31);
    init_tbl[10] = mk(8'hB3, 1, 80'hF0);
    init_tbl[11] = mk(8'h8A, 1, 80'h64);
    init_tbl[12] = mk(8'h8B, 1, 80'h78);
    init_tbl[13] = mk(8'h8C, 1, 80'h64);
    init_tbl[14] = mk(8'hBB, 1, 80'h3A);
    init_tbl[15] = mk(8'hBE, 1, 80'h3E);
    init_tbl[16] = mk(8'h87, 1, 80'h06);
    init_tbl[17] = mk(8'h81, 1, 80'h91);
    init_tbl[18] = mk(8'h82, 1, 80'h50);
    init_tbl[19] = mk(8'h83, 1, 80'h7D);
    init_tbl[20] = mk(8'h2E, 0, 80'h0);
    init_tbl[21] = mk(8'h15, 2, 80'h5F00);
    init_tbl[22] = mk(8'h75, 2, 80'h3F00);
    init_tbl[23] = mk(8'hBC, 0, 80'h0);
    init_tbl[24] = mk(8'h26, 1, 80'h01);
    init_tbl[25] = mk(8'h22, 10, 80'h3F5F0000);
    init_tbl[26] = mk(8'h25, 4, 80'h3F5F0000);
    init_tbl[27] = mk(8'hAF, 0, 80'h0);

    pix_tbl[0] = mp(16'hF800, 7'd16, 6'd5);
    pix_tbl[1] = mp(16'h07E0, 7'd17, 6'd5);
    pix_tbl[2] = mp(16'h001F, 7'd18, 6'd5);
    pix_tbl[3] = mp(16'hFFFF, 7'd16, 6'd6);
    pix_tbl[4] = mp(16'h0000, 7'd17, 6'd6);
    pix_tbl[5] = mp(16'h1234, 7'd18, 6'd6);
    pix_tbl[6] = mp(16'hBEEF, 7'd16, 6'd5);

    wait_clk(5);
    check_zero("reset");
    resetn = 1'b1;
    wait_clk(3);
    spi_cs = 1'b0;
    wait_clk(10);

    // init stream
    c0 = n_cmds;
    for (int i = 0; i < 28; i++) send_cmd(init_tbl[i]);
    drain("init");
    check("init_cmd_count", n_cmds - c0, 28);
    check("init_display_on", display_on, 1);

    // window and pixel walk
    send_cmd(mk(8'h15, 2, 80'h1210));
    send_cmd(mk(8'h75, 2, 80'h0605));
    for (int i = 0; i < 7; i++) send_pix(pix_tbl[i]);
    drain("window");

    // edge column and start>end window
    send_cmd(mk(8'h75, 2, 80'h3F00));
    send_cmd(mk(8'h15, 2, 80'h5F5F));
    send_pix(mp(16'hA001, 7'd95, 6'd0));
    send_pix(mp(16'hA002, 7'd95, 6'd1));
    send_cmd(mk(8'h15, 2, 80'h5E60));
    send_pix(mp(16'hB001, 7'd96, 6'd2));
    send_pix(mp(16'hB002, 7'd97, 6'd2));
    drain("edge");

    // cs abort mid-byte
    b0 = n_bytes;
    spi_dc = 1'b0;
    send_bits(8'hA5, 5);
    spi_cs = 1'b1;
    wait_clk(10);
    spi_cs = 1'b0;
    wait_clk(10);
    send_cmd(mk(8'h3C, 0, 80'h0));
    drain("abort");
    check("abort_byte_count", n_bytes - b0, 1);

    // command byte clears pixel phase
    send_cmd(mk(8'hAE, 0, 80'h0));
    drain("off");
    check("display_off", display_on, 0);
    p0 = n_pix;
    exp_bytes.push_back({1'b1, 8'hAB});
    spi_dc = 1'b1;
    send_bits(8'hAB, 8);
    send_cmd(mk(8'hAF, 0, 80'h0));
    send_pix(mp(16'h1234, 7'd98, 6'd2));
    drain("phase");
    check("phase_pix_count", n_pix - p0, 1);
    check("phase_display_on", display_on, 1);

    // reset in the middle of a draw-rect argument list
    spi_dc = 1'b0;
    exp_bytes.push_back({1'b0, 8'h22});
    send_bits(8'h22, 8);
    exp_bytes.push_back({1'b0, 8'h00});
    send_bits(8'h00, 8);
    send_bits(8'h05, 4);
    resetn = 1'b0;
    wait_clk(2);
    check_zero("midcmd_reset");
    check("midcmd_reset_bytes_left", exp_bytes.size(), 0);
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    wait_clk(2);
    resetn = 1'b1;
    wait_clk(5);
    spi_cs = 1'b0;
    wait_clk(10);
    send_cmd(mk(8'hAF, 0, 80'h0));
    drain("after_reset");
    check("after_reset_cmd_op", cmd_op, 8'hAF);
    check("after_reset_display_on", display_on, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
